instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter AW, default 8, sets the instruction address and PC width.
REQ-002 Parameter DW, default 16, sets the instruction word width.
REQ-003 Parameter TMO, default 15, sets the maximum number of WAIT cycles before the fetch is aborted.
REQ-004 clk  in  1  single clock; all state updates on the posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 FETCH  in  1  CU request to fetch the word at PC.
REQ-007 JMP  in  1  CU request to load PC from JADDR.
REQ-008 JADDR  in  AW  jump target.
REQ-009 IM_ADDR  out  AW  instruction memory address.
REQ-010 IM_RD  out  1  instruction memory read strobe.
REQ-011 IM_DATA  in  DW  instruction memory read data.
REQ-012 IM_VALID  in  1  IM_DATA valid, same cycle.
REQ-013 IR_DATA  out  DW  word to the instruction register data input.
REQ-014 IR_WR  out  1  instruction register write strobe.
REQ-015 PC  out  AW  current program counter.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 DONE  out  1  one-cycle pulse when a word is handed to the IR.
REQ-018 ERR  out  1  one-cycle pulse on memory timeout.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, WAIT, LOAD and ABORT.
REQ-020 IDLE with FETCH=1 SHALL go to ADDR next cycle; FETCH outside IDLE SHALL be ignored.
REQ-021 IDLE with JMP=1 SHALL load PC<=JADDR; JMP outside IDLE SHALL be ignored.
REQ-022 JMP and FETCH in the same IDLE cycle SHALL load PC from JADDR and fetch from JADDR.
REQ-023 In ADDR and WAIT: IM_RD=1 and IM_ADDR=PC; IM_RD=0 in all other states.
REQ-024 ADDR SHALL go to LOAD if IM_VALID=1, else to WAIT.
REQ-025 WAIT SHALL go to LOAD on IM_VALID=1.
REQ-026 On the IM_VALID cycle, IM_DATA SHALL be captured into the IR_DATA register; IR_DATA SHALL hold between fetches.
REQ-027 WAIT cycle counter SHALL clear on entry to ADDR; after TMO WAIT cycles without IM_VALID, the FSM SHALL go to ABORT.
REQ-028 IM_VALID on the TMO-th WAIT cycle SHALL win over timeout.
REQ-029 LOAD SHALL assert IR_WR=1 and DONE=1 for exactly one cycle, set PC<=PC+1 (mod 2^AW, so all-ones wraps to 0), and return to IDLE.
REQ-030 ABORT SHALL assert ERR=1 for one cycle with no IR_WR and PC unchanged, then return to IDLE.
REQ-031 IM_VALID in IDLE, LOAD or ABORT SHALL be ignored.
REQ-032 Latency with zero-wait memory: FETCH at cycle 0, IM_RD at cycle 1, IR_WR/DONE at cycle 2; earliest next FETCH accepted at cycle 3.

Reset
REQ-033 rst=1 SHALL force IDLE, PC=0, IR_DATA=0, wait counter 0, and IM_RD=IR_WR=BUSY=DONE=ERR=0 on the next edge, from any state.
REQ-034 rst asserted mid-fetch SHALL suppress any pending IR_WR; an IM_VALID in the same cycle SHALL be dropped.
REQ-035 rst SHALL take priority over FETCH and JMP.

Structure
REQ-036 A shared package fetch_pkg SHALL hold the state enum and the default AW, DW and TMO constants.
REQ-037 The wait counter SHALL be a sub-module fetch_timer (clear, enable, expired output).
REQ-038 No other sub-modules; all outputs registered except IM_ADDR (=PC).

Verification
REQ-039 Zero-wait: reset, FETCH at cycle 0, IM_VALID tied 1 with IM_DATA=16'hA5C3 -> IR_WR and DONE high at cycle 2 only, IR_DATA=16'hA5C3, PC 0->1.
REQ-040 Wait states: IM_VALID at the 3rd WAIT cycle with IM_DATA=16'h1234 -> IM_RD held high through ADDR and WAIT, IR_WR one cycle later, PC=1.
REQ-041 Timeout: TMO=15, IM_VALID never asserted -> ERR pulse after 15 WAIT cycles, no IR_WR, PC unchanged, BUSY low afterwards.
REQ-042 Jump+fetch: JMP=1, JADDR=8'h40 and FETCH=1 in the same IDLE cycle -> IM_ADDR=8'h40, PC=8'h41 after LOAD; JMP asserted during WAIT -> ignored.
REQ-043 Wrap: JMP to 8'hFF, then a fetch -> PC=8'h00 after LOAD.
REQ-044 Reset mid-fetch: rst in WAIT coincident with IM_VALID -> next cycle IDLE, PC=0, IR_DATA=0, no IR_WR or DONE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry,
// memory timeout and the fetch FSM state encoding.
package fetch_pkg;

    localparam int AW_DEF  = 8;
    localparam int DW_DEF  = 16;
    localparam int TMO_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle between the fetch unit, the control unit, the instruction memory
// and the instruction register. The fetch unit is the slave side.
interface instr_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          fetch;
    logic          jmp;
    logic [AW-1:0] jaddr;
    logic [AW-1:0] im_addr;
    logic          im_rd;
    logic [DW-1:0] im_data;
    logic          im_valid;
    logic [DW-1:0] ir_data;
    logic          ir_wr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output fetch, jmp, jaddr, im_data, im_valid,
        input  im_addr, im_rd, ir_data, ir_wr, pc, busy, done, err
    );

    modport slave (
        input  fetch, jmp, jaddr, im_data, im_valid,
        output im_addr, im_rd, ir_data, ir_wr, pc, busy, done, err
    );

endinterface

// File: rtl/fetch_timer.sv
// Counts memory WAIT cycles; o_expired flags the TMO-th WAIT cycle so the
// FSM can abort if the word has still not arrived.
module fetch_timer #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == CW'(TMO - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads one word from instruction memory
// per FETCH request and hands it to the instruction register.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int TMO = TMO_DEF
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ir_data;
    logic          r_im_rd;
    logic          r_ir_wr;
    logic          r_done;
    logic          r_err;
    logic          r_busy;
    logic          w_mem_phase;
    logic          w_capture;
    logic          w_expired;

    assign w_mem_phase = (r_state == ST_ADDR) || (r_state == ST_WAIT);
    assign w_capture   = w_mem_phase && bus.im_valid;

    // Counter is held clear in ADDR and only advances while in WAIT.
    fetch_timer #(.TMO(TMO)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == ST_ADDR),
        .i_en      (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    // NOTE: defaulting the next state first keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.fetch) w_state_nxt = ST_ADDR;
            ST_ADDR:  w_state_nxt = bus.im_valid ? ST_LOAD : ST_WAIT;
            // A word arriving on the last allowed WAIT cycle beats the timeout.
            ST_WAIT: begin
                if (bus.im_valid)   w_state_nxt = ST_LOAD;
                else if (w_expired) w_state_nxt = ST_ABORT;
            end
            ST_LOAD:  w_state_nxt = ST_IDLE;
            ST_ABORT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir_data <= '0;
            r_im_rd   <= 1'b0;
            r_ir_wr   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && bus.jmp) begin
                r_pc <= bus.jaddr;
            end else if (r_state == ST_LOAD) begin
                r_pc <= r_pc + AW'(1);
            end
            if (w_capture) begin
                r_ir_data <= bus.im_data;
            end
            r_im_rd <= (w_state_nxt == ST_ADDR) || (w_state_nxt == ST_WAIT);
            r_ir_wr <= (w_state_nxt == ST_LOAD);
            r_done  <= (w_state_nxt == ST_LOAD);
            r_err   <= (w_state_nxt == ST_ABORT);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.im_addr = r_pc;
    assign bus.im_rd   = r_im_rd;
    assign bus.ir_data = r_ir_data;
    assign bus.ir_wr   = r_ir_wr;
    assign bus.pc      = r_pc;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for the cycle-by-cycle
// behaviour plus hand sequences for the timeout paths.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        string       name;
        logic        rst;
        logic        fetch;
        logic        jmp;
        logic [7:0]  jaddr;
        logic        valid;
        logic [15:0] data;
        logic        rd;
        logic        wr;
        logic        done;
        logic        err;
        logic        busy;
        logic [7:0]  pc;
        logic [15:0] ir;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    instr_fetch_if #(.AW(8), .DW(16)) bus ();

    instr_fetch #(.AW(8), .DW(16), .TMO(15)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack_out(logic rd, logic wr, logic done, logic err,
                                             logic busy, logic [7:0] pc, logic [7:0] addr,
                                             logic [15:0] ir);
        return {27'd0, rd, wr, done, err, busy, pc, addr, ir};
    endfunction

    function automatic logic [63:0] dut_out();
        return pack_out(bus.im_rd, bus.ir_wr, bus.done, bus.err, bus.busy,
                        bus.pc, bus.im_addr, bus.ir_data);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (rd,wr,done,err,busy,pc,addr,ir)",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic j, input logic [7:0] ja,
                         input logic v, input logic [15:0] d);
        rst          = r;
        bus.fetch    = f;
        bus.jmp      = j;
        bus.jaddr    = ja;
        bus.im_valid = v;
        bus.im_data  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[23];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(H, L, L, 8'h00, L, 16'h0000);

        //           name           rst fet jmp jaddr  vld data      rd wr dn er bsy pc     ir
        tbl[0]  = '{"reset",        H, L, L, 8'h00, L, 16'h0000, L, L, L, L, L, 8'h00, 16'h0000};
        tbl[1]  = '{"zw_addr",      L, H, L, 8'h00, H, 16'hA5C3, H, L, L, L, H, 8'h00, 16'h0000};
        tbl[2]  = '{"zw_load",      L, L, L, 8'h00, H, 16'hA5C3, L, H, H, L, H, 8'h00, 16'hA5C3};
        tbl[3]  = '{"zw_idle",      L, H, L, 8'h00, H, 16'hFFFF, L, L, L, L, L, 8'h01, 16'hA5C3};
        tbl[4]  = '{"ws_addr",      L, H, L, 8'h00, L, 16'h0000, H, L, L, L, H, 8'h01, 16'hA5C3};
        tbl[5]  = '{"ws_wait1",     L, H, L, 8'h00, L, 16'h0000, H, L, L, L, H, 8'h01, 16'hA5C3};
        tbl[6]  = '{"ws_wait2_jmp", L, L, H, 8'h77, L, 16'h0000, H, L, L, L, H, 8'h01, 16'hA5C3};
        tbl[7]  = '{"ws_wait3",     L, L, L, 8'h00, L, 16'h0000, H, L, L, L, H, 8'h01, 16'hA5C3};
        tbl[8]  = '{"ws_load",      L, L, L, 8'h00, H, 16'h1234, L, H, H, L, H, 8'h01, 16'h1234};
        tbl[9]  = '{"ws_idle",      L, L, L, 8'h00, L, 16'h0000, L, L, L, L, L, 8'h02, 16'h1234};
        tbl[10] = '{"jf_addr",      L, H, H, 8'h40, L, 16'h0000, H, L, L, L, H, 8'h40, 16'h1234};
        tbl[11] = '{"jf_load",      L, L, L, 8'h00, H, 16'hBEEF, L, H, H, L, H, 8'h40, 16'hBEEF};
        tbl[12] = '{"jf_idle",      L, L, L, 8'h00, L, 16'h0000, L, L, L, L, L, 8'h41, 16'hBEEF};
        tbl[13] = '{"wr_jmp",       L, L, H, 8'hFF, L, 16'h0000, L, L, L, L, L, 8'hFF, 16'hBEEF};
        tbl[14] = '{"wr_addr",      L, H, L, 8'h00, L, 16'h0000, H, L, L, L, H, 8'hFF, 16'hBEEF};
        tbl[15] = '{"wr_load",      L, L, L, 8'h00, H, 16'h0F0F, L, H, H, L, H, 8'hFF, 16'h0F0F};
        tbl[16] = '{"wr_idle",      L, L, L, 8'h00, L, 16'h0000, L, L, L, L, L, 8'h00, 16'h0F0F};
        tbl[17] = '{"rm_jmp",       L, L, H, 8'h21, L, 16'h0000, L, L, L, L, L, 8'h21, 16'h0F0F};
        tbl[18] = '{"rm_addr",      L, H, L, 8'h00, L, 16'h0000, H, L, L, L, H, 8'h21, 16'h0F0F};
        tbl[19] = '{"rm_wait",      L, L, L, 8'h00, L, 16'h0000, H, L, L, L, H, 8'h21, 16'h0F0F};
        tbl[20] = '{"rm_rst_valid", H, L, L, 8'h00, H, 16'h5555, L, L, L, L, L, 8'h00, 16'h0000};
        tbl[21] = '{"rst_priority", H, H, H, 8'h33, L, 16'h0000, L, L, L, L, L, 8'h00, 16'h0000};
        tbl[22] = '{"post_rst",     L, L, L, 8'h00, H, 16'h9999, L, L, L, L, L, 8'h00, 16'h0000};

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].fetch, tbl[i].jmp, tbl[i].jaddr, tbl[i].valid, tbl[i].data);
            step();
            check(tbl[i].name, dut_out(),
                  pack_out(tbl[i].rd, tbl[i].wr, tbl[i].done, tbl[i].err, tbl[i].busy,
                           tbl[i].pc, tbl[i].pc, tbl[i].ir));
        end

        // Timeout: 15 WAIT cycles with no data, then a one-cycle ERR.
        drive(L, L, H, 8'h10, L, 16'h0000);
        step();
        drive(L, H, L, 8'h00, L, 16'h0000);
        step();
        check("to_addr", dut_out(), pack_out(H, L, L, L, H, 8'h10, 8'h10, 16'h0000));
        drive(L, L, L, 8'h00, L, 16'h0000);
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("to_wait%0d", k), dut_out(),
                  pack_out(H, L, L, L, H, 8'h10, 8'h10, 16'h0000));
        end
        step();
        check("to_abort", dut_out(), pack_out(L, L, L, H, H, 8'h10, 8'h10, 16'h0000));
        step();
        check("to_idle", dut_out(), pack_out(L, L, L, L, L, 8'h10, 8'h10, 16'h0000));

        // Data on the 15th WAIT cycle wins over the timeout.
        drive(L, H, L, 8'h00, L, 16'h0000);
        step();
        drive(L, L, L, 8'h00, L, 16'h0000);
        for (int k = 1; k <= 15; k++) step();
        check("edge_wait15", dut_out(), pack_out(H, L, L, L, H, 8'h10, 8'h10, 16'h0000));
        drive(L, L, L, 8'h00, H, 16'hC0DE);
        step();
        check("edge_load", dut_out(), pack_out(L, H, H, L, H, 8'h10, 8'h10, 16'hC0DE));
        drive(L, L, L, 8'h00, L, 16'h0000);
        step();
        check("edge_idle", dut_out(), pack_out(L, L, L, L, L, 8'h11, 8'h11, 16'hC0DE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
